fix_session_ctrl: RTL and testbench

- Connection scheduler between the application and the TOE-facing request FIFO in front of fix_engine.
- Latches per-host connect and disconnect requests from the application.
- Grants one request at a time, round-robin across hosts, and drives the connect and disconnect request signals to the FIFO.
- Tracks per-host connected state and retries timed-out connects before reporting failure.

---
 rtl/fix_pkg.sv | 16 +
 rtl/fix_rr_arbiter.sv | 27 ++
 rtl/fix_session_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fix_session_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared types and default sizing for the FIX session controller slice.
package fix_pkg;

    localparam int DEF_NUM_HOSTS = 4;
    localparam int DEF_HOST_W    = 2;

    typedef logic [DEF_HOST_W-1:0] host_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        CONN_REQ,
        CONN_WAIT,
        DISC_REQ
    } sess_state_e;

endpackage

// File: rtl/fix_rr_arbiter.sv
// Round-robin pick: the first set request at or after ptr_i+1, wrapping modulo N.
module fix_rr_arbiter
    import fix_pkg::*;
#(
    parameter int N = DEF_NUM_HOSTS,
    parameter int W = DEF_HOST_W
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_o   = '0;
        valid_o = 1'b0;
        // Scan from lowest to highest priority so the last hit, i.e. ptr_i+1, wins.
        for (int i = N; i >= 1; i--) begin
            if (req_i[W'((int'(ptr_i) + i) % N)]) begin
                gnt_o   = W'((int'(ptr_i) + i) % N);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fix_session_ctrl.sv
// Connection scheduler: latches per-host connect/disconnect requests, grants one at a
// time round-robin (disconnects first), retries timed-out connects and tracks link state.
module fix_session_ctrl
    import fix_pkg::*;
#(
    parameter int NUM_HOSTS    = DEF_NUM_HOSTS,
    parameter int HOST_W       = DEF_HOST_W,
    parameter int CONN_TIMEOUT = 1000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HOSTS-1:0] conn_req_i,
    input  logic [NUM_HOSTS-1:0] disc_req_i,
    input  logic                 connected_i,
    input  logic [HOST_W-1:0]    connected_host_addr_i,
    input  logic                 peer_closed_i,
    input  logic [HOST_W-1:0]    peer_closed_addr_i,
    input  logic                 fifo_ready_i,
    output logic                 connect_req_o,
    output logic [HOST_W-1:0]    connect_addr_o,
    output logic                 disconnect_o,
    output logic [HOST_W-1:0]    disconnect_host_num_o,
    output logic [NUM_HOSTS-1:0] host_connected_o,
    output logic                 conn_fail_o,
    output logic [HOST_W-1:0]    fail_host_o,
    output logic                 busy_o
);

    localparam int TMR_W = $clog2(CONN_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    sess_state_e          state_q, state_d;
    logic [HOST_W-1:0]    grant_q, grant_d, rr_q, rr_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_HOSTS-1:0] conn_pend_q, conn_pend_d, disc_pend_q, disc_pend_d;
    logic [NUM_HOSTS-1:0] linked_q, linked_d;
    logic                 fail_d;

    logic                 connect_req_q, disconnect_q, conn_fail_q, busy_q;
    logic [HOST_W-1:0]    connect_addr_q, disc_addr_q, fail_host_q;

    logic [HOST_W-1:0]    disc_gnt, conn_gnt;
    logic                 disc_vld, conn_vld;

    fix_rr_arbiter #(.N(NUM_HOSTS), .W(HOST_W)) u_disc_arb (
        .req_i   (disc_pend_q & linked_q),
        .ptr_i   (rr_q),
        .gnt_o   (disc_gnt),
        .valid_o (disc_vld)
    );

    fix_rr_arbiter #(.N(NUM_HOSTS), .W(HOST_W)) u_conn_arb (
        .req_i   (conn_pend_q & ~linked_q),
        .ptr_i   (rr_q),
        .gnt_o   (conn_gnt),
        .valid_o (conn_vld)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        linked_d    = linked_q;
        conn_pend_d = conn_pend_q;
        disc_pend_d = disc_pend_q;
        fail_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Ineligible requests are dropped as they are scanned.
                conn_pend_d = conn_pend_q & ~linked_q;
                disc_pend_d = disc_pend_q & linked_q;
                if (disc_vld) begin
                    state_d              = DISC_REQ;
                    grant_d              = disc_gnt;
                    rr_d                 = disc_gnt;
                    disc_pend_d[disc_gnt] = 1'b0;
                end else if (conn_vld) begin
                    state_d              = CONN_REQ;
                    grant_d              = conn_gnt;
                    rr_d                 = conn_gnt;
                    retry_d              = RTY_W'(1);
                    conn_pend_d[conn_gnt] = 1'b0;
                end
            end
            CONN_REQ: begin
                if (fifo_ready_i) begin
                    state_d = CONN_WAIT;
                    timer_d = '0;
                end
            end
            CONN_WAIT: begin
                if (connected_i && connected_host_addr_i == grant_q) begin
                    linked_d[grant_q] = 1'b1;
                    state_d           = IDLE;
                end else if (timer_q == TMR_W'(CONN_TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        state_d = CONN_REQ;
                        retry_d = retry_q + RTY_W'(1);
                    end else begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timer_q != {TMR_W{1'b1}}) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DISC_REQ: begin
                if (fifo_ready_i) begin
                    linked_d[grant_q] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A same-cycle disconnect cancels the connect for that host.
        conn_pend_d = (conn_pend_d | conn_req_i) & ~(conn_req_i & disc_req_i);
        disc_pend_d = disc_pend_d | disc_req_i;

        if (peer_closed_i) linked_d[peer_closed_addr_i] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            rr_q           <= '0;
            retry_q        <= '0;
            timer_q        <= '0;
            conn_pend_q    <= '0;
            disc_pend_q    <= '0;
            linked_q       <= '0;
            connect_req_q  <= 1'b0;
            connect_addr_q <= '0;
            disconnect_q   <= 1'b0;
            disc_addr_q    <= '0;
            conn_fail_q    <= 1'b0;
            fail_host_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_q           <= rr_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            conn_pend_q    <= conn_pend_d;
            disc_pend_q    <= disc_pend_d;
            linked_q       <= linked_d;
            connect_req_q  <= (state_d == CONN_REQ);
            connect_addr_q <= (state_d == CONN_REQ) ? grant_d : '0;
            disconnect_q   <= (state_d == DISC_REQ);
            disc_addr_q    <= (state_d == DISC_REQ) ? grant_d : '0;
            conn_fail_q    <= fail_d;
            fail_host_q    <= fail_d ? grant_q : '0;
            busy_q         <= (state_d != IDLE);
        end
    end

    assign connect_req_o         = connect_req_q;
    assign connect_addr_o        = connect_addr_q;
    assign disconnect_o          = disconnect_q;
    assign disconnect_host_num_o = disc_addr_q;
    assign host_connected_o      = linked_q;
    assign conn_fail_o           = conn_fail_q;
    assign fail_host_o           = fail_host_q;
    assign busy_o                = busy_q;

endmodule

// File: tb/tb_fix_session_ctrl.sv
// Directed bench for fix_session_ctrl with a scoreboard of expected FIFO accepts and fail pulses.
module tb_fix_session_ctrl;
    import fix_pkg::*;

    localparam int NH      = 4;
    localparam int TIMEOUT = 8;
    localparam int RETRY   = 3;

    localparam logic [1:0] EV_CONN  = 2'd1;
    localparam logic [1:0] EV_DISC  = 2'd2;
    localparam logic [1:0] EV_ABORT = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NH-1:0]   conn_req_i = '0, disc_req_i = '0;
    logic            connected_i = 1'b0, peer_closed_i = 1'b0, fifo_ready_i = 1'b1;
    host_addr_t      connected_host_addr_i = '0, peer_closed_addr_i = '0;
    logic            connect_req_o, disconnect_o, conn_fail_o, busy_o;
    host_addr_t      connect_addr_o, disconnect_host_num_o, fail_host_o;
    logic [NH-1:0]   host_connected_o;

    int              n_vec = 0;
    int              n_err = 0;
    logic [3:0]      sb[$];

    fix_session_ctrl #(.NUM_HOSTS(NH), .HOST_W(2), .CONN_TIMEOUT(TIMEOUT), .MAX_RETRY(RETRY)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .conn_req_i            (conn_req_i),
        .disc_req_i            (disc_req_i),
        .connected_i           (connected_i),
        .connected_host_addr_i (connected_host_addr_i),
        .peer_closed_i         (peer_closed_i),
        .peer_closed_addr_i    (peer_closed_addr_i),
        .fifo_ready_i          (fifo_ready_i),
        .connect_req_o         (connect_req_o),
        .connect_addr_o        (connect_addr_o),
        .disconnect_o          (disconnect_o),
        .disconnect_host_num_o (disconnect_host_num_o),
        .host_connected_o      (host_connected_o),
        .conn_fail_o           (conn_fail_o),
        .fail_host_o           (fail_host_o),
        .busy_o                (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return connect_req_o;
            1:       return disconnect_o;
            default: return conn_fail_o;
        endcase
    endfunction

    task automatic wait_high(input int which, input int bound, input string tag);
        int n = 0;
        while (sig_of(which) !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(sig_of(which)), 32'd1);
    endtask

    task automatic pulse_connected(input host_addr_t a);
        connected_i = 1'b1;
        connected_host_addr_i = a;
        tick();
        connected_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Scoreboard: every FIFO accept and every fail pulse must match the next queued event.
    always @(negedge clk) begin
        if (rst && (((connect_req_o || disconnect_o) && fifo_ready_i) || conn_fail_o)) begin
            logic [3:0] obs;
            obs = conn_fail_o   ? {EV_ABORT, fail_host_o} :
                  connect_req_o ? {EV_CONN, connect_addr_o} : {EV_DISC, disconnect_host_num_o};
            if (sb.size() == 0) check("sb_unexpected", 32'(obs), 32'h0);
            else                check("sb_event", 32'(obs), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        host_addr_t order [3];
        int gap;
        order[0] = 2'd1; order[1] = 2'd3; order[2] = 2'd0;

        // Reset state
        #1;
        check("rst_outputs", 32'({connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
                                  host_connected_o, conn_fail_o, fail_host_o, busy_o}), 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Basic connect with latency check
        sb.push_back({EV_CONN, 2'd0});
        conn_req_i = 4'b0001;
        tick();
        conn_req_i = '0;
        check("lat_not_yet", 32'(connect_req_o), 32'd0);
        tick();
        check("lat_req", 32'(connect_req_o), 32'd1);
        check("lat_addr", 32'(connect_addr_o), 32'd0);
        check("lat_busy", 32'(busy_o), 32'd1);
        tick();
        check("req_one_cycle", 32'(connect_req_o), 32'd0);
        tick();
        tick();
        pulse_connected(2'd0);
        check("basic_connected", 32'(host_connected_o), 32'b0001);
        check("basic_idle", 32'(busy_o), 32'd0);

        // Round-robin from a fresh pointer
        apply_reset();
        check("rst_clears_link", 32'(host_connected_o), 32'd0);
        for (int i = 0; i < 3; i++) sb.push_back({EV_CONN, order[i]});
        conn_req_i = 4'b1011;
        tick();
        conn_req_i = '0;
        for (int i = 0; i < 3; i++) begin
            wait_high(0, 20, "rr_req");
            check("rr_addr", 32'(connect_addr_o), 32'(order[i]));
            tick();
            pulse_connected(order[i]);
        end
        check("rr_connected", 32'(host_connected_o), 32'b1011);

        // Connect for an already-connected host is dropped silently
        conn_req_i = 4'b0001;
        tick();
        conn_req_i = '0;
        tick();
        tick();
        check("silent_drop", 32'({busy_o, connect_req_o}), 32'd0);

        // Timeout and retry on host 2
        for (int i = 0; i < RETRY; i++) sb.push_back({EV_CONN, 2'd2});
        sb.push_back({EV_ABORT, 2'd2});
        conn_req_i = 4'b0100;
        tick();
        conn_req_i = '0;
        wait_high(0, 20, "retry_first_req");
        for (int a = 0; a < RETRY; a++) begin
            tick();
            gap = 0;
            while (!connect_req_o && !conn_fail_o && gap < 50) begin
                tick();
                gap++;
            end
            check("retry_gap", 32'(gap), 32'(TIMEOUT));
            if (a < RETRY - 1) check("retry_req", 32'(connect_req_o), 32'd1);
        end
        check("fail_pulse", 32'(conn_fail_o), 32'd1);
        check("fail_host", 32'(fail_host_o), 32'd2);
        check("fail_not_linked", 32'(host_connected_o[2]), 32'd0);
        check("fail_idle", 32'(busy_o), 32'd0);
        tick();
        check("fail_one_cycle", 32'(conn_fail_o), 32'd0);

        // Remote close in IDLE
        peer_closed_i = 1'b1;
        peer_closed_addr_i = 2'd3;
        tick();
        peer_closed_i = 1'b0;
        check("peer_close_idle", 32'(host_connected_o), 32'b0011);

        // Backpressure on a disconnect with a competing connect
        sb.push_back({EV_DISC, 2'd1});
        sb.push_back({EV_CONN, 2'd3});
        fifo_ready_i = 1'b0;
        disc_req_i = 4'b0010;
        conn_req_i = 4'b1000;
        tick();
        disc_req_i = '0;
        conn_req_i = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({disconnect_o, disconnect_host_num_o, connect_req_o}), 32'b1010);
            if (i == 4) fifo_ready_i = 1'b1;
            tick();
        end
        check("bp_released", 32'(disconnect_o), 32'd0);
        check("bp_unlinked", 32'(host_connected_o), 32'b0001);
        wait_high(0, 5, "bp_conn_follows");
        check("bp_conn_addr", 32'(connect_addr_o), 32'd3);
        tick();
        pulse_connected(2'd3);
        check("bp_conn_done", 32'(host_connected_o), 32'b1001);

        // Edge events while waiting on host 2
        sb.push_back({EV_CONN, 2'd2});
        conn_req_i = 4'b0100;
        tick();
        conn_req_i = '0;
        wait_high(0, 5, "edge_req");
        tick();
        peer_closed_i = 1'b1;
        peer_closed_addr_i = 2'd0;
        pulse_connected(2'd1);
        peer_closed_i = 1'b0;
        check("edge_links", 32'(host_connected_o), 32'b1000);
        check("edge_still_wait", 32'({busy_o, connect_req_o}), 32'b10);
        pulse_connected(2'd2);
        check("edge_done", 32'(host_connected_o), 32'b1100);
        check("edge_idle", 32'(busy_o), 32'd0);

        // Reset in the middle of CONN_REQ
        fifo_ready_i = 1'b0;
        conn_req_i = 4'b0001;
        tick();
        conn_req_i = '0;
        wait_high(0, 5, "mid_req");
        rst = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
                                      host_connected_o, conn_fail_o, fail_host_o, busy_o}), 32'h0);
        tick();
        fifo_ready_i = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", 32'({connect_req_o, conn_fail_o, busy_o}), 32'd0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
